// File: rtl/jpeg_bit_reader.sv
// JPEG entropy-scan bit reader: strips 0xFF00 stuffing and 0xFF fill bytes,
// halts on markers, and serves 0..16-bit MSB-first fields from a 32-bit buffer.
module jpeg_bit_reader #(
  parameter int BUF_W   = 32,
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        rd_req,
  input  logic [4:0]  rd_len,
  output logic        rd_ack,
  output logic [15:0] rd_bits,
  output logic [5:0]  bit_count,
  output logic        marker_valid,
  output logic [7:0]  marker_code,
  input  logic        marker_clr
);

  // Handshakes: a byte moves on an edge with in_valid && in_ready; a read
  // is consumed on an edge with rd_req && len <= bit_count, and rd_ack
  // pulses for one cycle afterwards with the field on rd_bits.

  localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);
  localparam logic [5:0] FULL_C    = 6'(BUF_W);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_GOT_FF = 2'd1,
    ST_MARKER = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BUF_W-1:0]  bit_buf;
  logic [BUF_W-1:0]  buf_next;
  logic [BUF_W-1:0]  shifted;
  logic [BUF_W-1:0]  field_wide;
  logic [5:0]        count_next;
  logic [5:0]        remain;
  logic [5:0]        len_eff;
  logic [5:0]        field_shift;
  logic              rd_fire;
  logic              accept;
  logic              append;
  logic [7:0]        append_byte;
  logic              marker_set;

  assign len_eff  = ({1'b0, rd_len} > MAX_LEN_C) ? MAX_LEN_C : {1'b0, rd_len};
  assign rd_fire  = rd_req && (len_eff <= bit_count);
  // A full byte of headroom is required so an append never overflows,
  // even when no read happens on the same edge.
  assign in_ready = (state != ST_MARKER) && (bit_count <= (FULL_C - 6'd8));
  assign accept   = in_valid && in_ready;

  // Input byte classification FSM.
  always_comb begin
    state_next  = state;
    append      = 1'b0;
    append_byte = in_data;
    marker_set  = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (accept) begin
          if (in_data == 8'hFF) state_next = ST_GOT_FF;
          else                  append     = 1'b1;
        end
      end
      ST_GOT_FF: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            append      = 1'b1;
            append_byte = 8'hFF;
            state_next  = ST_NORMAL;
          end else if (in_data != 8'hFF) begin
            marker_set = 1'b1;
            state_next = ST_MARKER;
          end
        end
      end
      ST_MARKER: begin
        if (marker_clr) state_next = ST_NORMAL;
      end
      default: state_next = ST_NORMAL;
    endcase
  end

  // Buffer update: shift out the consumed field first, then drop the new
  // byte directly beneath whatever bits remain.
  always_comb begin
    shifted    = rd_fire ? (bit_buf << len_eff) : bit_buf;
    remain     = bit_count - (rd_fire ? len_eff : 6'd0);
    buf_next   = shifted;
    count_next = remain;
    if (append) begin
      buf_next   = shifted | ({append_byte, {(BUF_W-8){1'b0}}} >> remain);
      count_next = remain + 6'd8;
    end
    field_shift = MAX_LEN_C - len_eff;
    field_wide  = {{(BUF_W-16){1'b0}}, bit_buf[BUF_W-1 -: 16]} >> field_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_NORMAL;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf   <= '0;
      bit_count <= 6'd0;
      rd_ack    <= 1'b0;
      rd_bits   <= 16'h0000;
    end else begin
      bit_buf   <= buf_next;
      bit_count <= count_next;
      rd_ack    <= rd_fire;
      if (rd_fire) rd_bits <= field_wide[15:0];
    end
  end

  // marker_code is kept after marker_clr so it can still be inspected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      marker_valid <= 1'b0;
      marker_code  <= 8'h00;
    end else if (marker_set) begin
      marker_valid <= 1'b1;
      marker_code  <= in_data;
    end else if ((state == ST_MARKER) && marker_clr) begin
      marker_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jpeg_bit_reader.sv
// Directed bench for jpeg_bit_reader: a table of push/read/clear vectors
// followed by hand sequences for the multi-cycle corner cases.
module tb_jpeg_bit_reader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rd_req;
  logic [4:0]  rd_len;
  logic        rd_ack;
  logic [15:0] rd_bits;
  logic [5:0]  bit_count;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_clr;

  int errors = 0;
  int checks = 0;

  jpeg_bit_reader dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rd_req(rd_req), .rd_len(rd_len), .rd_ack(rd_ack), .rd_bits(rd_bits),
    .bit_count(bit_count),
    .marker_valid(marker_valid), .marker_code(marker_code),
    .marker_clr(marker_clr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_PUSH, OP_READ, OP_CLR} op_t;

  typedef struct {
    op_t         op;
    logic [7:0]  data;
    logic [4:0]  len;
    logic [15:0] exp_bits;
    logic [5:0]  exp_count;
    logic        exp_mv;
    logic [7:0]  exp_code;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input op_t op, input logic [7:0] data, input logic [4:0] len,
                     input logic [15:0] bits, input logic [5:0] cnt, input logic mv,
                     input logic [7:0] code, input logic rdy);
    vec_t v;
    v.op = op; v.data = data; v.len = len; v.exp_bits = bits;
    v.exp_count = cnt; v.exp_mv = mv; v.exp_code = code; v.exp_ready = rdy;
    vecs.push_back(v);
  endtask

  // Driver tasks: inputs change on the falling edge, outputs sampled there too.
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] len, input logic [15:0] exp, input string name);
    @(negedge clk);
    rd_req = 1'b1;
    rd_len = len;
    @(negedge clk);
    rd_req = 1'b0;
    check({name, " ack"}, {31'd0, rd_ack}, 32'd1);
    check({name, " bits"}, {16'd0, rd_bits}, {16'd0, exp});
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    case (v.op)
      OP_PUSH: push_byte(v.data);
      OP_READ: do_read(v.len, v.exp_bits, tag);
      default: begin
        @(negedge clk);
        marker_clr = 1'b1;
        @(negedge clk);
        marker_clr = 1'b0;
      end
    endcase
    check({tag, " bit_count"}, {26'd0, bit_count}, {26'd0, v.exp_count});
    check({tag, " marker_valid"}, {31'd0, marker_valid}, {31'd0, v.exp_mv});
    check({tag, " marker_code"}, {24'd0, marker_code}, {24'd0, v.exp_code});
    check({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, v.exp_ready});
  endtask

  task automatic check_reset_values(input string name);
    check({name, " bit_count"}, {26'd0, bit_count}, 32'd0);
    check({name, " rd_ack"}, {31'd0, rd_ack}, 32'd0);
    check({name, " rd_bits"}, {16'd0, rd_bits}, 32'd0);
    check({name, " marker_valid"}, {31'd0, marker_valid}, 32'd0);
    check({name, " marker_code"}, {24'd0, marker_code}, 32'd0);
    check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    rd_req = 1'b0; rd_len = 5'd0; marker_clr = 1'b0;

    // Basic read
    add(OP_PUSH, 8'hA5, 0, 0,       6'd8,  0, 8'h00, 1);
    add(OP_PUSH, 8'h3C, 0, 0,       6'd16, 0, 8'h00, 1);
    add(OP_READ, 0, 5'd4, 16'h000A, 6'd12, 0, 8'h00, 1);
    add(OP_READ, 0, 5'd8, 16'h0053, 6'd4,  0, 8'h00, 1);
    add(OP_READ, 0, 5'd4, 16'h000C, 6'd0,  0, 8'h00, 1);
    // Unstuffing
    add(OP_PUSH, 8'hFF, 0, 0,        6'd0,  0, 8'h00, 1);
    add(OP_PUSH, 8'h00, 0, 0,        6'd8,  0, 8'h00, 1);
    add(OP_PUSH, 8'h12, 0, 0,        6'd16, 0, 8'h00, 1);
    add(OP_READ, 0, 5'd16, 16'hFF12, 6'd0,  0, 8'h00, 1);
    // Fill bytes and marker, read during marker, clear
    add(OP_PUSH, 8'h80, 0, 0,       6'd8, 0, 8'h00, 1);
    add(OP_PUSH, 8'hFF, 0, 0,       6'd8, 0, 8'h00, 1);
    add(OP_PUSH, 8'hFF, 0, 0,       6'd8, 0, 8'h00, 1);
    add(OP_PUSH, 8'hD9, 0, 0,       6'd8, 1, 8'hD9, 0);
    add(OP_READ, 0, 5'd3, 16'h0004, 6'd5, 1, 8'hD9, 0);
    add(OP_CLR,  0, 0, 0,           6'd5, 0, 8'hD9, 1);
    add(OP_READ, 0, 5'd5, 16'h0000, 6'd0, 0, 8'hD9, 1);
    // Zero-length read, length clamp (20 acts as 16)
    add(OP_READ, 0, 5'd0,  16'h0000, 6'd0,  0, 8'hD9, 1);
    add(OP_PUSH, 8'h12, 0, 0,        6'd8,  0, 8'hD9, 1);
    add(OP_PUSH, 8'h34, 0, 0,        6'd16, 0, 8'hD9, 1);
    add(OP_PUSH, 8'h56, 0, 0,        6'd24, 0, 8'hD9, 1);
    add(OP_READ, 0, 5'd20, 16'h1234, 6'd8,  0, 8'hD9, 1);
    add(OP_READ, 0, 5'd8,  16'h0056, 6'd0,  0, 8'hD9, 1);
    add(OP_PUSH, 8'hAB, 0, 0,        6'd8,  0, 8'hD9, 1);

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Append and read on the same edge: 0xAB buffered, push 0xCD while reading 4
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hCD; rd_req = 1'b1; rd_len = 5'd4;
    @(negedge clk);
    in_valid = 1'b0; rd_req = 1'b0;
    check("simul ack", {31'd0, rd_ack}, 32'd1);
    check("simul bits", {16'd0, rd_bits}, 32'h000A);
    check("simul count", {26'd0, bit_count}, 32'd12);
    do_read(5'd12, 16'h0BCD, "simul tail");
    check("simul tail count", {26'd0, bit_count}, 32'd0);

    // Backpressure: four bytes fill the buffer, a fifth is held off
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    check("bp full count", {26'd0, bit_count}, 32'd32);
    check("bp full ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (2) @(negedge clk);
    check("bp held count", {26'd0, bit_count}, 32'd32);
    rd_req = 1'b1; rd_len = 5'd16;
    @(negedge clk);
    rd_req = 1'b0;
    check("bp read bits", {16'd0, rd_bits}, 32'h1122);
    check("bp read count", {26'd0, bit_count}, 32'd16);
    check("bp reopen ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp fifth count", {26'd0, bit_count}, 32'd24);
    do_read(5'd16, 16'h3344, "bp r2");
    do_read(5'd8, 16'h0055, "bp r3");

    // Starvation: 4 bits buffered, a 5-bit request waits for the next byte
    push_byte(8'h9F);
    do_read(5'd4, 16'h0009, "starve pre");
    @(negedge clk);
    rd_req = 1'b1; rd_len = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("starve no ack", {31'd0, rd_ack}, 32'd0);
    end
    in_valid = 1'b1; in_data = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    check("starve early ack", {31'd0, rd_ack}, 32'd0);
    check("starve count", {26'd0, bit_count}, 32'd12);
    @(negedge clk);
    rd_req = 1'b0;
    check("starve ack", {31'd0, rd_ack}, 32'd1);
    check("starve bits", {16'd0, rd_bits}, 32'h001F);
    do_read(5'd7, 16'h0000, "starve tail");

    // Reset while in GOT_FF with 12 bits buffered
    push_byte(8'hAB); push_byte(8'hCD);
    do_read(5'd4, 16'h000A, "rst pre");
    push_byte(8'hFF);
    check("rst pre count", {26'd0, bit_count}, 32'd12);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    #1;
    check_reset_values("mid reset");
    @(negedge clk);
    check("reset no accept", {26'd0, bit_count}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    push_byte(8'h00);
    check("post reset count", {26'd0, bit_count}, 32'd8);
    do_read(5'd8, 16'h0000, "post reset");
    check("post reset marker", {31'd0, marker_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
